// File: rtl/quant_sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : quant_sample_packer
// Description : Packs N_DIG-bit quantized samples LSB-first into W_WORD-bit
//               words and streams them out over valid/ready. Provides
//               start/abort control, zero-padded flush of a final partial
//               word, end-of-capture marking and sticky overflow reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module quant_sample_packer #(
  parameter int N_DIG  = 3,
  parameter int W_WORD = 32,
  parameter int N_LEN  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_DIG-1:0]  dat_in,
  input  logic              valid_in,
  input  logic              start,
  input  logic              abort,
  input  logic [N_LEN-1:0]  length,
  output logic [W_WORD-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [N_LEN-1:0]  word_cnt
);

  // Samples per word and the width of the slot index
  localparam int c_SPW = W_WORD / N_DIG;
  localparam int c_SW  = (c_SPW > 1) ? $clog2(c_SPW) : 1;
  localparam logic [c_SW-1:0]  c_SLOT_LAST = c_SW'(c_SPW - 1);
  localparam logic [c_SW-1:0]  c_SLOT_ONE  = c_SW'(1);
  localparam logic [N_LEN-1:0] c_LEN_ONE   = N_LEN'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_FLUSH   = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [N_LEN-1:0]   r_len;
  logic [N_LEN-1:0]   r_cnt;
  logic [c_SW-1:0]    r_slot;
  logic [W_WORD-1:0]  r_asm;

  logic [W_WORD-1:0]  r_fifo_data [2];
  logic [1:0]         r_fifo_last;
  logic               r_rd_ptr;
  logic               r_wr_ptr;
  logic [1:0]         r_count;

  logic [N_LEN-1:0]   r_word_cnt;
  logic               r_overflow;

  logic               w_start_ok;
  logic               w_accept;
  logic [N_LEN-1:0]   w_cnt_inc;
  logic               w_final;
  logic               w_word_full;
  logic [W_WORD-1:0]  w_asm_next;
  logic               w_push;
  logic [W_WORD-1:0]  w_push_data;
  logic               w_push_last;
  logic               w_pop;
  logic               w_full;
  logic               w_push_ok;
  logic               w_drop;
  logic               w_drain_done;

  assign m_valid  = (r_count != 2'd0);
  assign m_data   = r_fifo_data[r_rd_ptr];
  assign m_last   = m_valid & r_fifo_last[r_rd_ptr];
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign word_cnt = r_word_cnt;

  // Sample acceptance, word completion and FIFO push/pop qualification
  always_comb begin
    w_start_ok   = start & ~abort & (r_state == S_IDLE);
    w_accept     = (r_state == S_CAPTURE) & valid_in & (r_cnt != r_len);
    w_cnt_inc    = r_cnt + c_LEN_ONE;
    w_final      = w_accept & (w_cnt_inc == r_len);
    w_word_full  = w_accept & (r_slot == c_SLOT_LAST);
    w_push       = ~abort & (w_word_full | (r_state == S_FLUSH));
    w_push_data  = (r_state == S_FLUSH) ? r_asm : w_asm_next;
    w_push_last  = (r_state == S_FLUSH) ? 1'b1 : w_final;
    w_pop        = m_valid & m_ready;
    w_full       = (r_count == 2'd2);
    w_push_ok    = w_push & (~w_full | w_pop);
    w_drop       = w_push & w_full & ~w_pop;
    w_drain_done = (r_count == 2'd0) | ((r_count == 2'd1) & w_pop);
  end

  // Assembly register with the incoming sample inserted; slot 0 starts a fresh, zeroed word
  always_comb begin
    w_asm_next = (r_slot == '0) ? '0 : r_asm;
    for (int s = 0; s < c_SPW; s++) begin
      if (r_slot == c_SW'(s)) begin
        w_asm_next[s*N_DIG +: N_DIG] = dat_in;
      end
    end
  end

  // Capture control FSM with registered busy/done
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_slot  <= '0;
      r_asm   <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_slot  <= '0;
        r_asm   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start_ok) begin
              r_len  <= length;
              r_cnt  <= '0;
              r_slot <= '0;
              r_asm  <= '0;
              r_busy <= 1'b1;
              if (length == '0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_CAPTURE;
              end
            end
          end
          S_CAPTURE: begin
            if (w_accept) begin
              r_cnt  <= w_cnt_inc;
              r_asm  <= w_asm_next;
              r_slot <= w_word_full ? '0 : (r_slot + c_SLOT_ONE);
              if (w_final) begin
                r_state <= w_word_full ? S_DRAIN : S_FLUSH;
              end
            end
          end
          S_FLUSH: begin
            r_state <= S_DRAIN;
            r_slot  <= '0;
            r_asm   <= '0;
          end
          S_DRAIN: begin
            if (w_drain_done) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Two-entry output FIFO; a dropped last word moves the last tag onto the tail entry
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last    <= '0;
      r_rd_ptr       <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_count        <= 2'd0;
    end else if (abort) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last    <= '0;
      r_rd_ptr       <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_count        <= 2'd0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_push_ok) begin
        r_fifo_data[r_wr_ptr] <= w_push_data;
        r_fifo_last[r_wr_ptr] <= w_push_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end else if (w_drop && w_push_last) begin
        r_fifo_last[~r_wr_ptr] <= 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating accepted-word counter and sticky overflow flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_word_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (w_start_ok) begin
      r_word_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop && (r_word_cnt != '1)) begin
        r_word_cnt <= r_word_cnt + c_LEN_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_quant_sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_quant_sample_packer
// Description : Directed self-checking bench for quant_sample_packer
//               (N_DIG=3, W_WORD=32, N_LEN=16, 10 samples per word).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quant_sample_packer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  dat_in;
  logic        valid_in;
  logic        start;
  logic        abort;
  logic [15:0] length;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] word_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int done_cyc = 0;
  logic [31:0] q_data[$];
  logic        q_last[$];
  int          q_cyc[$];

  quant_sample_packer #(.N_DIG(3), .W_WORD(32), .N_LEN(16)) dut (
    .clk(clk), .resetn(resetn), .dat_in(dat_in), .valid_in(valid_in),
    .start(start), .abort(abort), .length(length),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done), .overflow(overflow), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number e, cyc == e
  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor: records handshakes (popped at the next edge) and done pulses
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      q_data.push_back(m_data);
      q_last.push_back(m_last);
      q_cyc.push_back(cyc);
    end
    if (done) begin
      n_done   = n_done + 1;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic q_clear();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  task automatic do_start(input logic [15:0] len);
    start  = 1'b1;
    length = len;
    step();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int base, input int max);
    int k = 0;
    while (n_done == base && k < max) begin
      step();
      k++;
    end
    n_vec++; if (n_done != base + 1) begin n_err++; $display("FAIL done_pulse: got %0d pulses, want 1", n_done - base); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after_done: got %b want 0", busy); end
  endtask

  task automatic test_reset();
    n_vec++; if (m_data !== 32'h0) begin n_err++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    n_vec++; if (overflow !== 1'b0 || word_cnt !== 16'h0) begin n_err++; $display("FAIL reset_ovf_cnt: got %b/%0d want 0/0", overflow, word_cnt); end
  endtask

  // length=20, samples 0..19 (3-bit wrap), continuous valid, m_ready=1
  task automatic test_continuous();
    int s, base;
    q_clear(); base = n_done; m_ready = 1'b1;
    do_start(16'd20); s = cyc;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL cont_busy_after_start: got %b want 1", busy); end
    for (int i = 0; i < 20; i++) begin valid_in = 1'b1; dat_in = 3'(i); step(); end
    valid_in = 1'b0;
    wait_done(base, 20);
    n_vec++; if (q_data.size() != 2) begin n_err++; $display("FAIL cont_nwords: got %0d want 2", q_data.size()); end
    n_vec++; if (q_data.size() < 1 || q_data[0] !== 32'h08FAC688) begin n_err++; $display("FAIL cont_word0: got %h want 08fac688", (q_data.size() > 0) ? q_data[0] : 32'hx); end
    n_vec++; if (q_data.size() < 2 || q_data[1] !== 32'h1A23EB1A) begin n_err++; $display("FAIL cont_word1: got %h want 1a23eb1a", (q_data.size() > 1) ? q_data[1] : 32'hx); end
    n_vec++; if (q_last.size() < 2 || q_last[0] !== 1'b0 || q_last[1] !== 1'b1) begin n_err++; $display("FAIL cont_last: got %0d tags want 0,1", q_last.size()); end
    n_vec++; if (q_cyc.size() < 1 || q_cyc[0] != s + 10) begin n_err++; $display("FAIL cont_latency: got cyc %0d want %0d", (q_cyc.size() > 0) ? q_cyc[0] : -1, s + 10); end
    n_vec++; if (q_cyc.size() < 2 || done_cyc != q_cyc[1] + 1) begin n_err++; $display("FAIL cont_done_timing: got cyc %0d want %0d", done_cyc, (q_cyc.size() > 1) ? q_cyc[1] + 1 : -1); end
    n_vec++; if (word_cnt !== 16'd2 || overflow !== 1'b0) begin n_err++; $display("FAIL cont_cnt_ovf: got %0d/%b want 2/0", word_cnt, overflow); end
  endtask

  // length=13, all samples 7: full word then 3-sample flushed word
  task automatic test_flush();
    int s, base;
    q_clear(); base = n_done; m_ready = 1'b1;
    do_start(16'd13); s = cyc;
    for (int i = 0; i < 13; i++) begin valid_in = 1'b1; dat_in = 3'd7; step(); end
    valid_in = 1'b0;
    wait_done(base, 20);
    n_vec++; if (q_data.size() != 2) begin n_err++; $display("FAIL flush_nwords: got %0d want 2", q_data.size()); end
    n_vec++; if (q_data.size() < 1 || q_data[0] !== 32'h3FFFFFFF || q_last[0] !== 1'b0) begin n_err++; $display("FAIL flush_word0: got %h want 3fffffff", (q_data.size() > 0) ? q_data[0] : 32'hx); end
    n_vec++; if (q_data.size() < 2 || q_data[1] !== 32'h000001FF || q_last[1] !== 1'b1) begin n_err++; $display("FAIL flush_word1: got %h want 000001ff with last", (q_data.size() > 1) ? q_data[1] : 32'hx); end
    n_vec++; if (q_cyc.size() < 2 || q_cyc[1] != s + 14) begin n_err++; $display("FAIL flush_timing: got cyc %0d want %0d", (q_cyc.size() > 1) ? q_cyc[1] : -1, s + 14); end
  endtask

  // length=30 with the consumer stalled: third word dropped, tail re-tagged last
  task automatic test_overflow();
    int base;
    q_clear(); base = n_done; m_ready = 1'b0;
    do_start(16'd30);
    for (int i = 0; i < 30; i++) begin
      valid_in = 1'b1; dat_in = 3'(i / 10 + 1); step();
      if (i == 24) begin
        n_vec++; if (m_data !== 32'h09249249 || m_valid !== 1'b1) begin n_err++; $display("FAIL ovf_stall_hold: got %h/%b want 09249249/1", m_data, m_valid); end
      end
    end
    valid_in = 1'b0;
    step();
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_vec++; if (m_last !== 1'b0 || busy !== 1'b1 || n_done != base) begin n_err++; $display("FAIL ovf_pending: last %b busy %b done %0d want 0,1,0", m_last, busy, n_done - base); end
    m_ready = 1'b1;
    wait_done(base, 10);
    n_vec++; if (q_data.size() != 2) begin n_err++; $display("FAIL ovf_nwords: got %0d want 2", q_data.size()); end
    n_vec++; if (q_data.size() < 2 || q_data[0] !== 32'h09249249 || q_data[1] !== 32'h12492492) begin n_err++; $display("FAIL ovf_words: got %0d words, want 09249249,12492492", q_data.size()); end
    n_vec++; if (q_last.size() < 2 || q_last[0] !== 1'b0 || q_last[1] !== 1'b1) begin n_err++; $display("FAIL ovf_retag: got %0d tags want 0,1", q_last.size()); end
    n_vec++; if (word_cnt !== 16'd2 || overflow !== 1'b1) begin n_err++; $display("FAIL ovf_cnt: got %0d/%b want 2/1", word_cnt, overflow); end
  endtask

  // valid_in toggling, samples before start and after the 10th ignored
  task automatic test_toggle_valid();
    int s, base;
    q_clear(); base = n_done; m_ready = 1'b1;
    valid_in = 1'b1; dat_in = 3'd7;
    step(); step();
    do_start(16'd10); s = cyc;
    for (int i = 0; i < 20; i++) begin
      valid_in = (i % 2 == 0);
      dat_in   = (i % 2 == 0) ? 3'(i / 2) : 3'd7;
      step();
    end
    valid_in = 1'b1; dat_in = 3'd7;
    step(); step(); step();
    valid_in = 1'b0;
    wait_done(base, 10);
    n_vec++; if (q_data.size() != 1) begin n_err++; $display("FAIL tog_nwords: got %0d want 1", q_data.size()); end
    n_vec++; if (q_data.size() < 1 || q_data[0] !== 32'h08FAC688 || q_last[0] !== 1'b1) begin n_err++; $display("FAIL tog_word: got %h want 08fac688 with last", (q_data.size() > 0) ? q_data[0] : 32'hx); end
    n_vec++; if (q_cyc.size() < 1 || q_cyc[0] != s + 19) begin n_err++; $display("FAIL tog_timing: got cyc %0d want %0d", (q_cyc.size() > 0) ? q_cyc[0] : -1, s + 19); end
    n_vec++; if (word_cnt !== 16'd1) begin n_err++; $display("FAIL tog_word_cnt: got %0d want 1", word_cnt); end
  endtask

  // abort mid-capture with a full FIFO and partial word, then a clean restart
  task automatic test_abort();
    int base;
    q_clear(); base = n_done; m_ready = 1'b0;
    do_start(16'd40);
    for (int i = 0; i < 35; i++) begin valid_in = 1'b1; dat_in = 3'd6; step(); end
    valid_in = 1'b0;
    n_vec++; if (m_valid !== 1'b1 || overflow !== 1'b1) begin n_err++; $display("FAIL abort_pre: valid %b ovf %b want 1,1", m_valid, overflow); end
    abort = 1'b1; start = 1'b1; length = 16'd5;
    step();
    abort = 1'b0; start = 1'b0;
    n_vec++; if (m_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_kill: valid %b busy %b want 0,0", m_valid, busy); end
    n_vec++; if (overflow !== 1'b1 || word_cnt !== 16'd0) begin n_err++; $display("FAIL abort_hold: ovf %b cnt %0d want 1,0", overflow, word_cnt); end
    step(); step(); step();
    n_vec++; if (n_done != base || busy !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses busy %b want 0,0", n_done - base, busy); end
    m_ready = 1'b1; base = n_done;
    do_start(16'd10);
    for (int i = 0; i < 10; i++) begin valid_in = 1'b1; dat_in = 3'd5; step(); end
    valid_in = 1'b0;
    wait_done(base, 10);
    n_vec++; if (q_data.size() != 1 || q_data[0] !== 32'h2DB6DB6D || q_last[0] !== 1'b1) begin n_err++; $display("FAIL abort_restart_word: got %0d words first %h want 1 word 2db6db6d", q_data.size(), (q_data.size() > 0) ? q_data[0] : 32'hx); end
    n_vec++; if (overflow !== 1'b0 || word_cnt !== 16'd1) begin n_err++; $display("FAIL abort_restart_ovf: ovf %b cnt %0d want 0,1", overflow, word_cnt); end
  endtask

  // length=0 goes straight to DONE
  task automatic test_zero_length();
    int base;
    q_clear(); base = n_done; m_ready = 1'b1;
    do_start(16'd0);
    n_vec++; if (busy !== 1'b1 || done !== 1'b1) begin n_err++; $display("FAIL zero_done_cycle: busy %b done %b want 1,1", busy, done); end
    step();
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL zero_after: busy %b done %b want 0,0", busy, done); end
    n_vec++; if (n_done != base + 1 || q_data.size() != 0) begin n_err++; $display("FAIL zero_stream: pulses %0d words %0d want 1,0", n_done - base, q_data.size()); end
  endtask

  // asynchronous reset mid-capture with a word pending and word_cnt non-zero
  task automatic test_async_reset();
    m_ready = 1'b1;
    do_start(16'd40);
    for (int i = 0; i < 21; i++) begin
      if (i == 12) m_ready = 1'b0;
      valid_in = 1'b1; dat_in = 3'd1; step();
    end
    n_vec++; if (m_valid !== 1'b1 || word_cnt !== 16'd1 || busy !== 1'b1) begin n_err++; $display("FAIL rst_pre: valid %b cnt %0d busy %b want 1,1,1", m_valid, word_cnt, busy); end
    #1 resetn = 1'b0;
    #1;
    n_vec++; if (m_valid !== 1'b0 || m_data !== 32'h0 || m_last !== 1'b0) begin n_err++; $display("FAIL rst_async_stream: valid %b data %h last %b want 0", m_valid, m_data, m_last); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0 || word_cnt !== 16'd0 || overflow !== 1'b0) begin n_err++; $display("FAIL rst_async_status: busy %b done %b cnt %0d ovf %b want 0", busy, done, word_cnt, overflow); end
    valid_in = 1'b0;
    step();
    resetn = 1'b1;
    step();
    n_vec++; if (m_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_release: valid %b busy %b want 0,0", m_valid, busy); end
  endtask

  initial begin
    resetn = 1'b0; valid_in = 1'b0; dat_in = 3'd0; start = 1'b0; abort = 1'b0;
    length = 16'd0; m_ready = 1'b0;
    #3;
    test_reset();
    step();
    resetn = 1'b1;
    step();
    test_continuous();
    test_flush();
    test_overflow();
    test_toggle_valid();
    test_abort();
    test_zero_length();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
